// File: rtl/ram_param.sv
//------------------------------------------------------------------------------
// ram_param: single-port synchronous RAM with optional hardware clear after reset
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_param #(
  parameter int DATA_W         = 4,
  parameter int ADDR_W         = 12,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ren_i,
  input  logic              wen_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              rvalid_o,
  output logic              busy_o,
  output logic              drop_o
);

  localparam int c_depth = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t c_rst_state = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic [DATA_W-1:0]   r_mem [c_depth];
  logic [DATA_W-1:0]   r_dout;
  logic                r_rvalid;
  logic                r_drop;
  logic                w_idle;
  logic                w_clear;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_rst_state;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    if (r_state == ST_CLEAR) begin
      w_ptr_nxt = r_ptr + 1'b1;
      // The all-ones pointer is the last word of the clear sweep
      if (&r_ptr) begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  assign w_idle  = (r_state == ST_IDLE);
  assign w_clear = (r_state == ST_CLEAR);

  // Clear sweep and user writes share the single write port; reset blocks both
  assign w_we    = !rst_i && (w_clear || wen_i);
  assign w_waddr = w_clear ? r_ptr : addr_i;
  assign w_wdata = w_clear ? '0 : din_i;

  always_ff @(posedge clk_i) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dout   <= '0;
      r_rvalid <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_rvalid <= w_idle && ren_i;
      r_drop   <= w_clear && (ren_i || wen_i);
      if (w_idle && ren_i) begin
        r_dout <= ((WRITE_FIRST != 0) && wen_i) ? din_i : r_mem[addr_i];
      end
    end
  end

  assign dout_o   = r_dout;
  assign rvalid_o = r_rvalid;
  assign drop_o   = r_drop;
  assign busy_o   = w_clear;

endmodule

`default_nettype wire
